dec_vp_value_table: RTL
=======================

// Module: dec_vp_value_table
// PURPOSE
//  Last-value prediction table: the producer of predicted results that the VP flush control checks.
//  Decode looks up by PC; one cycle later the block returns a 64-bit predicted value, gated by confidence.
//  The E4 resolution port writes back the actual result to train or replace entries.
//  Sits in dec beside the flush control: lookup from decode, update from the commit/E4 stage.
// PARAMETERS
//  INDEX_W      6    log2 of table entries (64 entries, direct-mapped)
//  TAG_W        10   partial PC tag bits stored per entry
//  CONF_W       2    saturating confidence counter width
//  CONF_THRESH  3    minimum confidence for pred_valid=1 (must be <= 2**CONF_W-1)
// PORTS
//  clk             in   1     single clock
//  rst             in   1     reset; asynchronous, active-high
//  freeze          in   1     pipeline freeze; holds lookup output register
//  flush           in   1     pipeline flush; kills the in-flight lookup
//  lookup_valid    in   1     decode requests a prediction this cycle
//  lookup_pc       in   63    [63:1] PC of instruction to predict
//  pred_valid      out  1     registered: prediction usable (hit and conf >= CONF_THRESH)
//  pred_hit        out  1     registered: tag hit, regardless of confidence
//  pred_value      out  64    registered: predicted result (0 when pred_hit=0)
//  upd_valid       in   1     resolved result available for training
//  upd_pc          in   63    [63:1] PC of the resolved instruction
//  upd_actual      in   64    actual result from execute
//  upd_mispredict  in   1     flush control raised a VP flush for this instruction
//  mispredict_cnt  out  32    saturating count of accepted upd_mispredict events
// BEHAVIOUR
//  Index = pc[INDEX_W:1]; tag = pc[INDEX_W+TAG_W:INDEX_W+1]; same split on lookup and update.
//  Entry state: valid(1), tag(TAG_W), value(64), conf(CONF_W).
//  Reset (async, rst=1): all entry valid bits = 0, conf = 0; pred_valid/pred_hit = 0,
//   pred_value = 0, mispredict_cnt = 0. Tag/value arrays need not be reset.
//  Lookup latency: 1 cycle. Cycle N samples lookup_pc; the output register loads at edge N+1.
//   freeze=1: output register holds its value; the new lookup is dropped.
//   flush=1 (freeze=0): output register loads pred_valid=0, pred_hit=0, pred_value=0.
//   lookup_valid=0 (no freeze/flush): outputs load 0.
//   pred_hit = entry.valid & tag match; pred_valid = pred_hit & (conf >= CONF_THRESH).
//  Update (applied at the clock edge when upd_valid=1; freeze does not block updates):
//   hit, upd_actual == value: conf = min(conf+1, 2**CONF_W-1); value unchanged.
//   hit, upd_actual != value: value = upd_actual; conf = 0.
//   miss (invalid or tag differs): allocate; valid = 1, tag = new, value = upd_actual, conf = 0.
//  upd_mispredict is a counter input only. The table outcome depends solely on the compare above.
//   mispredict_cnt += 1 when upd_valid & upd_mispredict; saturates at 32'hFFFF_FFFF.
//  Simultaneous lookup and update to the same index in one cycle: the lookup returns the
//   pre-update entry (read-before-write). The update is never lost.
//  Lookup and update are independent: a lookup never stalls an update, and an update never stalls a lookup.
//  Conf wrap is forbidden: it stays saturated at max and never wraps to 0.
//  Reset asserted mid-operation: the in-flight lookup is discarded and any same-cycle update is discarded.
// TESTING
//  1 Reset, then lookup pc=0x100 -> next cycle pred_hit=0, pred_valid=0, pred_value=0.
//  2 Update pc=0x100 val=0xAB four times, then lookup 0x100 -> pred_hit=1, pred_valid=1,
//    pred_value=0xAB (conf 0->3). After only three updates: pred_valid=0 (conf=2).
//  3 Entry at conf=3; update with 0xCD and upd_mispredict=1 -> lookup gives pred_value=0xCD,
//    pred_valid=0; mispredict_cnt=1.
//  4 Aliasing: train pc=0x100, then update pc=0x100+(1<<(INDEX_W+1)) -> lookup 0x100 misses.
//  5 Same-cycle lookup and update on pc=0x100 (old=0xAB, new=0xCD) -> output shows 0xAB;
//    the following lookup shows 0xCD.
//  6 flush with lookup -> outputs 0 next cycle. freeze for 3 cycles -> outputs hold.
//    Assert rst mid-stream -> outputs 0 immediately; all entries miss afterwards.

Source files
------------

// File: rtl/dec_vp_value_table_if.sv
// Lookup/update bus of the last-value prediction table.
// Handshake: lookup_valid and upd_valid are single-cycle qualifiers with no
// ready back-pressure; the table accepts every qualified request on the
// rising clock edge where it is high. pred_* are registered and answer the
// lookup sampled one edge earlier (subject to freeze/flush).
interface dec_vp_value_table_if;
  logic        freeze;
  logic        flush;
  logic        lookup_valid;
  logic [63:1] lookup_pc;
  logic        pred_valid;
  logic        pred_hit;
  logic [63:0] pred_value;
  logic        upd_valid;
  logic [63:1] upd_pc;
  logic [63:0] upd_actual;
  logic        upd_mispredict;
  logic [31:0] mispredict_cnt;

  modport master (
    output freeze, flush, lookup_valid, lookup_pc,
    output upd_valid, upd_pc, upd_actual, upd_mispredict,
    input  pred_valid, pred_hit, pred_value, mispredict_cnt
  );

  modport slave (
    input  freeze, flush, lookup_valid, lookup_pc,
    input  upd_valid, upd_pc, upd_actual, upd_mispredict,
    output pred_valid, pred_hit, pred_value, mispredict_cnt
  );
endinterface

// File: rtl/dec_vp_value_table.sv
// Direct-mapped last-value prediction table. Decode looks up by PC and gets
// a registered prediction one cycle later; the resolution port trains or
// replaces entries. Reads see the pre-update entry (read-before-write).
module dec_vp_value_table #(
  parameter int INDEX_W     = 6,
  parameter int TAG_W       = 10,
  parameter int CONF_W      = 2,
  parameter int CONF_THRESH = 3
) (
  input logic                  clk,
  input logic                  rst,
  dec_vp_value_table_if.slave  bus
);

  localparam int                ENTRIES  = 1 << INDEX_W;
  localparam logic [CONF_W-1:0] CONF_MAX = '1;
  localparam logic [CONF_W-1:0] CONF_TH  = CONF_THRESH[CONF_W-1:0];

  // Entry state; only valid/conf need a reset value.
  logic              valid_q [ENTRIES];
  logic [CONF_W-1:0] conf_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [63:0]       value_q [ENTRIES];

  logic              pred_valid_q, pred_valid_d;
  logic              pred_hit_q,   pred_hit_d;
  logic [63:0]       pred_value_q, pred_value_d;
  logic [31:0]       cnt_q,        cnt_d;

  logic [INDEX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  logic               lk_hit, up_hit, up_same;
  logic [CONF_W-1:0]  up_conf_d;
  logic               unused_pc_bits;

  assign lk_idx = bus.lookup_pc[INDEX_W:1];
  assign lk_tag = bus.lookup_pc[INDEX_W+TAG_W:INDEX_W+1];
  assign up_idx = bus.upd_pc[INDEX_W:1];
  assign up_tag = bus.upd_pc[INDEX_W+TAG_W:INDEX_W+1];
  assign unused_pc_bits = ^{bus.lookup_pc[63:INDEX_W+TAG_W+1],
                            bus.upd_pc[63:INDEX_W+TAG_W+1]};

  // Lookup: decide what the output register loads at the next edge.
  always_comb begin
    lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_valid_d = pred_valid_q;
    pred_hit_d   = pred_hit_q;
    pred_value_d = pred_value_q;
    if (!bus.freeze) begin
      if (bus.flush || !bus.lookup_valid) begin
        pred_valid_d = 1'b0;
        pred_hit_d   = 1'b0;
        pred_value_d = '0;
      end else begin
        pred_hit_d   = lk_hit;
        pred_valid_d = lk_hit && (conf_q[lk_idx] >= CONF_TH);
        pred_value_d = lk_hit ? value_q[lk_idx] : '0;
      end
    end
  end

  // Update: confidence grows on a matching hit, restarts on anything else.
  always_comb begin
    up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_same   = value_q[up_idx] == bus.upd_actual;
    up_conf_d = '0;
    if (up_hit && up_same) begin
      up_conf_d = (conf_q[up_idx] == CONF_MAX) ? CONF_MAX : conf_q[up_idx] + 1'b1;
    end
    cnt_d = cnt_q;
    if (bus.upd_valid && bus.upd_mispredict && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Resettable entry state and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        conf_q[i]  <= '0;
      end
      pred_valid_q <= 1'b0;
      pred_hit_q   <= 1'b0;
      pred_value_q <= '0;
      cnt_q        <= '0;
    end else begin
      if (bus.upd_valid) begin
        valid_q[up_idx] <= 1'b1;
        conf_q[up_idx]  <= up_conf_d;
      end
      pred_valid_q <= pred_valid_d;
      pred_hit_q   <= pred_hit_d;
      pred_value_q <= pred_value_d;
      cnt_q        <= cnt_d;
    end
  end

  // Tag/value payload; on a matching hit rewriting the same value is harmless.
  always_ff @(posedge clk) begin
    if (bus.upd_valid) begin
      tag_q[up_idx]   <= up_tag;
      value_q[up_idx] <= bus.upd_actual;
    end
  end

  assign bus.pred_valid     = pred_valid_q;
  assign bus.pred_hit       = pred_hit_q;
  assign bus.pred_value     = pred_value_q;
  assign bus.mispredict_cnt = cnt_q;

endmodule
